rx_fsm: RTL and testbench
=========================

# rx_fsm

Receive-side control FSM for the USB full-speed endpoint. It sits between the RX bit decoder/shift register and the RX data FIFO plus protocol controller, mirroring `tx_fsm` on the transmit side. It frames incoming packets byte by byte: SYNC check, PID decode and check, token address match, data byte forwarding to the FIFO and EOP handling. It reports the packet type, data readiness and errors to the protocol layer.

## Interface
- `DEV_ADDR`, default 7'h00: device address that token packets must match.
- `clk` input 1: system clock, all state on rising edge.
- `n_rst` input 1: asynchronous active-low reset.
- `d_edge` input 1: one-cycle pulse on the first line transition out of idle (packet start).
- `byte_received` input 1: one-cycle pulse; `rcv_data` holds a complete byte this cycle.
- `rcv_data` input 8: received byte, first-on-wire bit in bit 0.
- `eop` input 1: one-cycle pulse when SE0 end-of-packet is detected.
- `buff_occ` input 7: current RX FIFO occupancy, 0..64.
- `RX_packet` output 3: last packet type: 000 none, 001 OUT, 010 IN, 011 DATA0/DATA1, 100 ACK.
- `RX_Data_Ready` output 1: a valid data packet payload is in the FIFO.
- `RX_Transfer_Active` output 1: a packet is being received.
- `RX_Error` output 1: the last packet was malformed.
- `flush` output 1: one-cycle pulse clearing the RX FIFO at the start of a data payload.
- `store_rx_data` output 1: one-cycle FIFO write strobe.
- `rx_data` output 8: byte to write, valid while `store_rx_data` is high.

## Operation
- Byte constants:
  - SYNC = 8'h80.
  - PIDs: OUT 8'hE1, IN 8'h69, DATA0 8'hC3, DATA1 8'h4B, ACK 8'hD2.
  - PID check: `rcv_data[7:4] == ~rcv_data[3:0]`. Any PID failing the check or not in the list above is an error.
- IDLE: on `d_edge` go to SYNC_WAIT. Clear `RX_packet`, `RX_Error` and `RX_Data_Ready`. Set `RX_Transfer_Active`.
- SYNC_WAIT: on a byte, 8'h80 goes to PID_WAIT; any other byte goes to ERR.
- PID_WAIT: on a byte:
  - ACK goes to EOP_OK with type 100.
  - OUT or IN goes to TOKEN1, latching the type.
  - DATA0 or DATA1 goes to DATA_RCV, pulses `flush` and clears the byte counter.
  - Anything else goes to ERR.
- TOKEN1: on a byte, latch the address from `rcv_data[6:0]` and go to TOKEN2.
- TOKEN2: on a byte (endpoint and CRC5, not checked here), go to EOP_OK if the address equals `DEV_ADDR`, otherwise to IGNORE.
- DATA_RCV: on each byte:
  - If `buff_occ == 64`, go to ERR.
  - Otherwise pulse `store_rx_data` with `rx_data = rcv_data` and increment the 7-bit byte counter, saturating at 127.
  - On `eop`: counter ≥ 2 goes to DONE with type 011 and `RX_Data_Ready` set; counter < 2 goes to ERR.
- EOP_OK: `eop` goes to DONE, publishing the latched type. A further byte goes to ERR.
- IGNORE: drop all bytes; `eop` goes to IDLE with `RX_packet` = 000 and no error.
- ERR: set `RX_Error` and go to ERR_WAIT. Bytes are dropped; `eop` goes to IDLE.
- DONE: one cycle, then go to IDLE.
- Early EOP: `eop` in SYNC_WAIT, PID_WAIT, TOKEN1 or TOKEN2 goes to ERR.
- Priority: `eop` has priority over `byte_received` in the same cycle; that byte is discarded.
- `d_edge` outside IDLE is ignored.
- `RX_packet`, `RX_Error` and `RX_Data_Ready` hold from DONE/ERR until the next `d_edge` accepted in IDLE.

## Timing
- All outputs are registered and change on the clock edge after the triggering input cycle, i.e. one cycle of latency.
- Reset values: `RX_packet` 000, `rx_data` 8'h00; all 1-bit outputs 0; state IDLE; counter 0.
- Reset mid-packet returns to IDLE immediately and asynchronously; any partially received data is abandoned.
- `RX_Transfer_Active` rises the cycle after `d_edge` and falls the cycle after the `eop` that reaches DONE or IDLE.
  - Through ERR it falls the cycle after the `eop` seen in ERR_WAIT.
- `store_rx_data` and `rx_data` appear exactly one cycle after `byte_received`.
- `flush` appears one cycle after the DATA PID byte, which is always before the first `store_rx_data`.
- `RX_Data_Ready` and `RX_packet` = 011 rise together one cycle after the terminating `eop`.

## Test plan
- ACK packet (d_edge, 80, D2, eop) -> `RX_packet` = 100 one cycle after eop; `RX_Error` = 0; no store strobes.
- OUT token, `DEV_ADDR` = 7'h05 (80, E1, 05, xx, eop) -> `RX_packet` = 001. Same packet with address 06 -> `RX_packet` = 000, `RX_Error` = 0.
- DATA1 with bytes 3C, A5, 5A then eop -> one `flush`, three `store_rx_data` pulses with 3C/A5/5A, `RX_Data_Ready` = 1, `RX_packet` = 011.
- Bad SYNC (8'h81), bad PID (8'hC4), DATA0 followed by one byte then eop, and eop directly after the PID byte -> each sets `RX_Error` = 1 with `RX_packet` = 000; `RX_Transfer_Active` drops only after eop.
- DATA0 with `buff_occ` = 64 on the first byte -> no store, `RX_Error` = 1. A byte and eop in the same cycle -> byte not stored.
- `n_rst` asserted in DATA_RCV -> all outputs 0 at once; the next packet is received normally.

Source files
------------

// File: rtl/rx_fsm_if.sv
// Signal bundle between the RX bit decoder / FIFO side and the rx_fsm framing controller.
// master drives the decoder-side inputs; slave is the rx_fsm itself.
interface rx_fsm_if;
   logic       d_edge;
   logic       byte_received;
   logic [7:0] rcv_data;
   logic       eop;
   logic [6:0] buff_occ;
   logic [2:0] RX_packet;
   logic       RX_Data_Ready;
   logic       RX_Transfer_Active;
   logic       RX_Error;
   logic       flush;
   logic       store_rx_data;
   logic [7:0] rx_data;

   modport master (
      output d_edge, byte_received, rcv_data, eop, buff_occ,
      input  RX_packet, RX_Data_Ready, RX_Transfer_Active, RX_Error,
             flush, store_rx_data, rx_data
   );

   modport slave (
      input  d_edge, byte_received, rcv_data, eop, buff_occ,
      output RX_packet, RX_Data_Ready, RX_Transfer_Active, RX_Error,
             flush, store_rx_data, rx_data
   );
endinterface

// File: rtl/rx_fsm.sv
// USB full-speed receive framing FSM: SYNC/PID check, token address match,
// data payload forwarding to the RX FIFO and EOP handling, all outputs registered.
module rx_fsm #(
   parameter logic [6:0] DEV_ADDR = 7'h00
) (
   input  logic    clk,
   input  logic    n_rst,
   rx_fsm_if.slave bus
);

   localparam logic [7:0] SYNC_BYTE = 8'h80;
   localparam logic [7:0] PID_OUT   = 8'hE1;
   localparam logic [7:0] PID_IN    = 8'h69;
   localparam logic [7:0] PID_DATA0 = 8'hC3;
   localparam logic [7:0] PID_DATA1 = 8'h4B;
   localparam logic [7:0] PID_ACK   = 8'hD2;

   localparam logic [2:0] PKT_NONE = 3'b000;
   localparam logic [2:0] PKT_OUT  = 3'b001;
   localparam logic [2:0] PKT_IN   = 3'b010;
   localparam logic [2:0] PKT_DATA = 3'b011;
   localparam logic [2:0] PKT_ACK  = 3'b100;

   localparam logic [6:0] FIFO_FULL = 7'd64;

   typedef enum logic [3:0] {
      IDLE, SYNC_WAIT, PID_WAIT, TOKEN1, TOKEN2, DATA_RCV,
      EOP_OK, IGNORE, ERR, ERR_WAIT, DONE
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] type_q, type_d;
   logic [6:0] addr_q, addr_d;
   logic [6:0] cnt_q, cnt_d;
   logic [2:0] packet_q, packet_d;
   logic       ready_q, ready_d;
   logic       active_q, active_d;
   logic       error_q, error_d;
   logic       flush_q, flush_d;
   logic       store_q, store_d;
   logic [7:0] rx_data_q, rx_data_d;

   logic       pid_ok;
   logic       byte_err;
   logic       eop_err;

   assign pid_ok = (bus.rcv_data[7:4] == ~bus.rcv_data[3:0]);

   // NOTE: every variable gets its default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      type_d    = type_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      packet_d  = packet_q;
      ready_d   = ready_q;
      active_d  = active_q;
      error_d   = error_q;
      flush_d   = 1'b0;
      store_d   = 1'b0;
      rx_data_d = rx_data_q;
      byte_err  = 1'b0;
      eop_err   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.d_edge) begin
               state_d  = SYNC_WAIT;
               packet_d = PKT_NONE;
               error_d  = 1'b0;
               ready_d  = 1'b0;
               active_d = 1'b1;
            end
         end
         SYNC_WAIT: begin
            if (bus.eop) eop_err = 1'b1;
            else if (bus.byte_received) begin
               if (bus.rcv_data == SYNC_BYTE) state_d = PID_WAIT;
               else                           byte_err = 1'b1;
            end
         end
         PID_WAIT: begin
            if (bus.eop) eop_err = 1'b1;
            else if (bus.byte_received) begin
               if (!pid_ok) byte_err = 1'b1;
               else begin
                  case (bus.rcv_data)
                     PID_ACK: begin
                        type_d  = PKT_ACK;
                        state_d = EOP_OK;
                     end
                     PID_OUT: begin
                        type_d  = PKT_OUT;
                        state_d = TOKEN1;
                     end
                     PID_IN: begin
                        type_d  = PKT_IN;
                        state_d = TOKEN1;
                     end
                     PID_DATA0, PID_DATA1: begin
                        type_d  = PKT_DATA;
                        state_d = DATA_RCV;
                        flush_d = 1'b1;
                        cnt_d   = '0;
                     end
                     default: byte_err = 1'b1;
                  endcase
               end
            end
         end
         TOKEN1: begin
            if (bus.eop) eop_err = 1'b1;
            else if (bus.byte_received) begin
               addr_d  = bus.rcv_data[6:0];
               state_d = TOKEN2;
            end
         end
         TOKEN2: begin
            if (bus.eop) eop_err = 1'b1;
            else if (bus.byte_received)
               state_d = (addr_q == DEV_ADDR) ? EOP_OK : IGNORE;
         end
         DATA_RCV: begin
            if (bus.eop) begin
               if (cnt_q >= 7'd2) begin
                  state_d  = DONE;
                  packet_d = type_q;
                  ready_d  = 1'b1;
                  active_d = 1'b0;
               end else eop_err = 1'b1;
            end else if (bus.byte_received) begin
               if (bus.buff_occ == FIFO_FULL) byte_err = 1'b1;
               else begin
                  store_d   = 1'b1;
                  rx_data_d = bus.rcv_data;
                  if (cnt_q != 7'h7F) cnt_d = cnt_q + 7'd1;
               end
            end
         end
         EOP_OK: begin
            if (bus.eop) begin
               state_d  = DONE;
               packet_d = type_q;
               active_d = 1'b0;
            end else if (bus.byte_received) byte_err = 1'b1;
         end
         IGNORE: begin
            if (bus.eop) begin
               state_d  = IDLE;
               active_d = 1'b0;
            end
         end
         ERR: begin
            if (bus.eop) begin
               state_d  = IDLE;
               active_d = 1'b0;
            end else state_d = ERR_WAIT;
         end
         ERR_WAIT: begin
            if (bus.eop) begin
               state_d  = IDLE;
               active_d = 1'b0;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // An eop-triggered error already ends the packet, so it skips the wait for
      // another eop and Transfer_Active drops one cycle after that eop.
      if (eop_err) begin
         state_d  = IDLE;
         error_d  = 1'b1;
         active_d = 1'b0;
      end else if (byte_err) begin
         state_d  = ERR;
         error_d  = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         type_q    <= PKT_NONE;
         addr_q    <= '0;
         cnt_q     <= '0;
         packet_q  <= PKT_NONE;
         ready_q   <= 1'b0;
         active_q  <= 1'b0;
         error_q   <= 1'b0;
         flush_q   <= 1'b0;
         store_q   <= 1'b0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         type_q    <= type_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         packet_q  <= packet_d;
         ready_q   <= ready_d;
         active_q  <= active_d;
         error_q   <= error_d;
         flush_q   <= flush_d;
         store_q   <= store_d;
         rx_data_q <= rx_data_d;
      end
   end

   assign bus.RX_packet          = packet_q;
   assign bus.RX_Data_Ready      = ready_q;
   assign bus.RX_Transfer_Active = active_q;
   assign bus.RX_Error           = error_q;
   assign bus.flush              = flush_q;
   assign bus.store_rx_data      = store_q;
   assign bus.rx_data            = rx_data_q;

endmodule

// File: tb/tb_rx_fsm.sv
// Directed self-checking bench for rx_fsm: drives decoder pulses on the falling
// edge and checks the registered outputs one cycle later, also on a falling edge.
module tb_rx_fsm;

   logic clk;
   logic n_rst;
   int   n_tests;
   int   n_fail;
   int   store_cnt;
   int   flush_cnt;
   logic [7:0] store_log [256];

   rx_fsm_if bus ();

   rx_fsm #(.DEV_ADDR(7'h05)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe monitor: counts one-cycle pulses and logs stored bytes in order.
   always @(negedge clk) begin
      if (bus.store_rx_data) begin
         store_log[store_cnt[7:0]] = bus.rx_data;
         store_cnt = store_cnt + 1;
      end
      if (bus.flush) flush_cnt = flush_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_pkt();
      @(negedge clk);
      bus.d_edge = 1'b1;
      @(negedge clk);
      bus.d_edge = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.byte_received = 1'b1;
      bus.rcv_data      = b;
      @(negedge clk);
      bus.byte_received = 1'b0;
   endtask

   task automatic send_byte_eop(input logic [7:0] b);
      @(negedge clk);
      bus.byte_received = 1'b1;
      bus.rcv_data      = b;
      bus.eop           = 1'b1;
      @(negedge clk);
      bus.byte_received = 1'b0;
      bus.eop           = 1'b0;
   endtask

   task automatic send_eop();
      @(negedge clk);
      bus.eop = 1'b1;
      @(negedge clk);
      bus.eop = 1'b0;
   endtask

   task automatic gap();
      repeat (3) @(negedge clk);
   endtask

   task automatic check_err_pkt(input string tag);
      check({tag, "_err"},    32'(bus.RX_Error), 32'd1);
      check({tag, "_pkt"},    32'(bus.RX_packet), 32'd0);
      check({tag, "_active"}, 32'(bus.RX_Transfer_Active), 32'd0);
   endtask

   initial begin
      int base;
      n_tests           = 0;
      n_fail            = 0;
      store_cnt         = 0;
      flush_cnt         = 0;
      n_rst             = 1'b0;
      bus.d_edge        = 1'b0;
      bus.byte_received = 1'b0;
      bus.rcv_data      = 8'h00;
      bus.eop           = 1'b0;
      bus.buff_occ      = 7'd0;

      repeat (2) @(negedge clk);
      check("rst_pkt",    32'(bus.RX_packet), 32'd0);
      check("rst_rxdata", 32'(bus.rx_data), 32'h00);
      check("rst_1bit",   32'({bus.RX_Data_Ready, bus.RX_Transfer_Active, bus.RX_Error,
                                bus.flush, bus.store_rx_data}), 32'd0);
      n_rst = 1'b1;
      gap();

      // ACK handshake
      base = store_cnt;
      start_pkt();
      check("ack_active_rise", 32'(bus.RX_Transfer_Active), 32'd1);
      send_byte(8'h80);
      send_byte(8'hD2);
      check("ack_pkt_before_eop", 32'(bus.RX_packet), 32'd0);
      send_eop();
      check("ack_pkt",    32'(bus.RX_packet), 32'd4);
      check("ack_err",    32'(bus.RX_Error), 32'd0);
      check("ack_active", 32'(bus.RX_Transfer_Active), 32'd0);
      check("ack_stores", 32'(store_cnt - base), 32'd0);
      gap();

      // OUT token to our address
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hE1);
      send_byte(8'h05);
      send_byte(8'h3A);
      send_eop();
      check("out_match_pkt", 32'(bus.RX_packet), 32'd1);
      check("out_match_err", 32'(bus.RX_Error), 32'd0);
      gap();

      // OUT token to another address: silently ignored
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hE1);
      send_byte(8'h06);
      send_byte(8'h3A);
      send_eop();
      check("out_other_pkt",    32'(bus.RX_packet), 32'd0);
      check("out_other_err",    32'(bus.RX_Error), 32'd0);
      check("out_other_active", 32'(bus.RX_Transfer_Active), 32'd0);
      gap();

      // DATA1 payload of three bytes, with a stray d_edge mid-packet
      base = store_cnt;
      flush_cnt = 0;
      start_pkt();
      send_byte(8'h80);
      send_byte(8'h4B);
      check("d1_flush",        32'(bus.flush), 32'd1);
      check("d1_no_store_yet", 32'(bus.store_rx_data), 32'd0);
      send_byte(8'h3C);
      check("d1_store_lat", 32'({bus.store_rx_data, bus.rx_data}), 32'h13C);
      start_pkt();
      send_byte(8'hA5);
      send_byte(8'h5A);
      check("d1_ready_before_eop", 32'(bus.RX_Data_Ready), 32'd0);
      send_eop();
      check("d1_pkt",     32'(bus.RX_packet), 32'd3);
      check("d1_ready",   32'(bus.RX_Data_Ready), 32'd1);
      check("d1_err",     32'(bus.RX_Error), 32'd0);
      check("d1_flushes", 32'(flush_cnt), 32'd1);
      check("d1_stores",  32'(store_cnt - base), 32'd3);
      check("d1_byte0",   32'(store_log[8'(base)]), 32'h3C);
      check("d1_byte1",   32'(store_log[8'(base + 1)]), 32'hA5);
      check("d1_byte2",   32'(store_log[8'(base + 2)]), 32'h5A);
      gap();

      // Bad SYNC: error flagged at once, transfer active until eop
      start_pkt();
      check("bsync_clears_ready", 32'(bus.RX_Data_Ready), 32'd0);
      send_byte(8'h81);
      check("bsync_err_early",   32'(bus.RX_Error), 32'd1);
      check("bsync_active_held", 32'(bus.RX_Transfer_Active), 32'd1);
      send_byte(8'h55);
      check("bsync_active_held2", 32'(bus.RX_Transfer_Active), 32'd1);
      send_eop();
      check_err_pkt("bsync");
      gap();

      // Bad PID
      start_pkt();
      check("bpid_err_cleared", 32'(bus.RX_Error), 32'd0);
      send_byte(8'h80);
      send_byte(8'hC4);
      check("bpid_active_held", 32'(bus.RX_Transfer_Active), 32'd1);
      send_eop();
      check_err_pkt("bpid");
      gap();

      // DATA0 with a single byte is too short
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hC3);
      send_byte(8'h77);
      send_eop();
      check_err_pkt("short");
      check("short_ready", 32'(bus.RX_Data_Ready), 32'd0);
      gap();

      // eop straight after the PID byte
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hC3);
      send_eop();
      check_err_pkt("early_eop");
      gap();

      // FIFO full on the first payload byte
      base = store_cnt;
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hC3);
      bus.buff_occ = 7'd64;
      send_byte(8'h99);
      bus.buff_occ = 7'd0;
      check("full_no_store", 32'(store_cnt - base), 32'd0);
      check("full_err",      32'(bus.RX_Error), 32'd1);
      send_eop();
      check_err_pkt("full");
      gap();

      // Byte coincident with eop is discarded; two earlier bytes complete the packet
      base = store_cnt;
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hC3);
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte_eop(8'hCC);
      check("coinc_stores", 32'(store_cnt - base), 32'd2);
      check("coinc_last",   32'(store_log[8'(base + 1)]), 32'hBB);
      check("coinc_pkt",    32'(bus.RX_packet), 32'd3);
      check("coinc_ready",  32'(bus.RX_Data_Ready), 32'd1);
      gap();

      // Asynchronous reset in the middle of a payload
      start_pkt();
      send_byte(8'h80);
      send_byte(8'h4B);
      send_byte(8'h11);
      check("mid_store_before_rst", 32'(bus.store_rx_data), 32'd1);
      #2 n_rst = 1'b0;
      #1;
      check("mid_rst_outputs", 32'({bus.RX_packet, bus.RX_Data_Ready, bus.RX_Transfer_Active,
                                     bus.RX_Error, bus.flush, bus.store_rx_data, bus.rx_data}),
            32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      gap();
      start_pkt();
      send_byte(8'h80);
      send_byte(8'hD2);
      send_eop();
      check("post_rst_pkt", 32'(bus.RX_packet), 32'd4);
      check("post_rst_err", 32'(bus.RX_Error), 32'd0);
      gap();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
